// File: rtl/usb_aes_pkg.sv
// Shared types and sizes for the USB receive to AES block path.
package usb_aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int USB_BYTE_W      = 8;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] aes_block_t;

endpackage : usb_aes_pkg

// File: rtl/usb_rx_byte_fifo_regfile.sv
// fifo_regfile: DEPTH x WIDTH register array with one synchronous write
// port and one combinational read port. All entries reset to zero so the
// read port shows 0 straight out of reset.
module fifo_regfile #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, written one entry per accepted push.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_regfile

// File: rtl/usb_rx_byte_fifo.sv
// usb_rx_byte_fifo: show-ahead byte FIFO between the USB receiver and the
// AES block assembler. block_ready flags that a whole AES block is buffered.
// Optional sticky overflow/underflow outputs are built when the macro
// USB_RX_FIFO_ERR_FLAGS_EN is defined.
module usb_rx_byte_fifo
  import usb_aes_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WIDTH       = USB_BYTE_W,
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   write,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic                   block_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_acc;
  logic          wr_acc;
  logic          mem_we;

  // Flags decode the registered occupancy only.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign block_ready = (count_q >= CW'(BLOCK_BYTES));
  assign count       = count_q;

  // A full FIFO still takes a write when the head is leaving the same cycle.
  assign pop_acc = pop && !empty;
  assign wr_acc  = write && (!full || pop_acc);
  // A write that coincides with clear is discarded, not stored.
  assign mem_we  = wr_acc && !clear;

  // Next-state for pointers and occupancy; clear overrides both operations.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_acc && !pop_acc)      count_d = count_q + 1'b1;
      else if (pop_acc && !wr_acc) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef USB_RX_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; clear takes priority over a same-cycle set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (write && !wr_acc) ovf_d = 1'b1;
      if (pop && !pop_acc)  unf_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

  fifo_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

endmodule : usb_rx_byte_fifo

// File: tb/tb_usb_rx_byte_fifo.sv
// Testbench for usb_rx_byte_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the FIFO.
module tb_usb_rx_byte_fifo;

  localparam int DEPTH = 32;
  localparam int BLK   = 16;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       write;
  logic [7:0] wdata;
  logic       pop;
  logic [7:0] rdata;
  logic       empty;
  logic       full;
  logic       block_ready;
  logic [5:0] count;
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  usb_rx_byte_fifo #(
    .DEPTH       (DEPTH),
    .WIDTH       (8),
    .BLOCK_BYTES (BLK)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .write       (write),
    .wdata       (wdata),
    .pop         (pop),
    .rdata       (rdata),
    .empty       (empty),
    .full        (full),
    .block_ready (block_ready),
    .count       (count)
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents in arrival order plus the sticky flags.
  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_unf = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic w, input logic [7:0] d, input logic p, input logic c);
    bit pop_ok, wr_ok;
    if (c) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      pop_ok = p && (q.size() > 0);
      wr_ok  = w && ((q.size() < DEPTH) || pop_ok);
      if (pop_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(d);
      if (w && !wr_ok) m_ovf = 1;
      if (p && !pop_ok) m_unf = 1;
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    check_val("count", 32'(count), 32'(n));
    check_val("empty", 32'(empty), 32'(n == 0));
    check_val("full", 32'(full), 32'(n == DEPTH));
    check_val("block_ready", 32'(block_ready), 32'(n >= BLK));
    if (n > 0) check_val("rdata", 32'(rdata), 32'(q[0]));
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("underflow", 32'(underflow), 32'(m_unf));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_count"}, 32'(count), 32'd0);
    check_val({tag, "_empty"}, 32'(empty), 32'd1);
    check_val({tag, "_full"}, 32'(full), 32'd0);
    check_val({tag, "_block_ready"}, 32'(block_ready), 32'd0);
    check_val({tag, "_rdata"}, 32'(rdata), 32'h00);
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
    check_val({tag, "_overflow"}, 32'(overflow), 32'd0);
    check_val({tag, "_underflow"}, 32'(underflow), 32'd0);
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic step(input logic w, input logic [7:0] d, input logic p, input logic c);
    write = w;
    wdata = d;
    pop   = p;
    clear = c;
    @(posedge clk);
    model_step(w, d, p, c);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [7:0] exp_b;
    int wprob, pprob;

    write = 1'b0; wdata = 8'h00; pop = 1'b0; clear = 1'b0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_hold");
    @(negedge clk) n_rst = 1'b1;
    step(0, 8'h00, 0, 0);
    check_val("idle_rdata", 32'(rdata), 32'h00);

    // One block in, one block out.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    check_val("blk_ready_after16", 32'(block_ready), 32'd1);
    check_val("blk_count16", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check_val("blk_drain", 32'(rdata), 32'(i));
      step(0, 8'h00, 1, 0);
    end
    check_val("blk_empty", 32'(empty), 32'd1);

    // Fill to full, drop an extra write, drain everything.
    for (int i = 0; i < 32; i++) step(1, 8'hA0 + 8'(i), 0, 0);
    check_val("fill_full", 32'(full), 32'd1);
    step(1, 8'hFF, 0, 0);
    check_val("drop_count", 32'(count), 32'd32);
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
    check_val("drop_overflow", 32'(overflow), 32'd1);
`endif
    // Write and pop together while full.
    step(1, 8'hC0, 1, 0);
    check_val("full_wp_count", 32'(count), 32'd32);
    for (int i = 0; i < 32; i++) begin
      exp_b = (i < 31) ? 8'hA1 + 8'(i) : 8'hC0;
      check_val("full_drain", 32'(rdata), 32'(exp_b));
      step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 1);

    // Steady-state streaming at count 5 across pointer wraps.
    for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 64; i++) begin
      check_val("wrap_order", 32'(rdata), 32'(8'(i)));
      step(1, 8'(i + 5), 1, 0);
    end
    check_val("wrap_count", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);

    // Pop on empty, then write+pop on empty.
    step(0, 8'h00, 1, 0);
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
    check_val("underflow_set", 32'(underflow), 32'd1);
`endif
    step(1, 8'h5A, 1, 0);
    check_val("wp_empty_count", 32'(count), 32'd1);
    check_val("wp_empty_rdata", 32'(rdata), 32'h5A);
    step(0, 8'h00, 1, 0);

    // Clear with a concurrent write.
    for (int i = 0; i < 20; i++) step(1, 8'h30 + 8'(i), 0, 0);
    step(1, 8'h77, 0, 1);
    check_val("clear_count", 32'(count), 32'd0);
    check_val("clear_empty", 32'(empty), 32'd1);
    step(0, 8'h00, 0, 0);
    step(1, 8'h42, 0, 0);
    check_val("post_clear_rdata", 32'(rdata), 32'h42);

    // Asynchronous reset while draining.
    for (int i = 0; i < 18; i++) step(1, 8'h60 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    #2 n_rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    check_reset_outputs("async_rst");
    write = 1'b0; pop = 1'b0; clear = 1'b0;
    @(negedge clk) n_rst = 1'b1;

    // Randomized traffic with drifting write/pop bias.
    for (int ph = 0; ph < 6; ph++) begin
      wprob = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      pprob = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(0, 99) < wprob), 8'($urandom),
             ($urandom_range(0, 99) < pprob), ($urandom_range(0, 199) == 0));
      end
    end

    step(0, 8'h00, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_usb_rx_byte_fifo

// File: doc/usb_rx_byte_fifo.md
Name: usb_rx_byte_fifo

Overview:
- Byte-wide synchronous FIFO between the USB receive datapath and the 128-bit block assembler that feeds the AES core.
- Buffers plaintext bytes written by the USB receiver.
- Presents the head byte in show-ahead form and flags when a full 16-byte AES block is buffered.
- The assembler pops bytes one per cycle to build each block.

Parameters:
- DEPTH, 32, number of byte entries; power of two, at least BLOCK_BYTES.
- WIDTH, 8, data width in bits.
- BLOCK_BYTES, 16, occupancy threshold that asserts block_ready.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of contents and pointers.
- write  input  1  push wdata this cycle.
- wdata  input  WIDTH  byte from USB receiver.
- pop  input  1  consume head byte this cycle.
- rdata  output  WIDTH  head byte (show-ahead); valid when empty=0.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- block_ready  output  1  count>=BLOCK_BYTES.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (n_rst low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage entries = 0, so rdata=0.
  - empty=1, full=0, block_ready=0.
- Pointers:
  - Width $clog2(DEPTH).
  - Each increments by 1 on an accepted operation and wraps DEPTH-1 -> 0 by natural overflow.
- Write acceptance: accepted = write && (!full || pop_accepted).
  - An accepted write stores wdata at mem[wr_ptr] on the clock edge.
- Pop acceptance: accepted = pop && !empty. There is no show-through on empty.
- Count update, registered:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Flags:
  - empty, full and block_ready are combinational decodes of the registered count.
  - They reflect a push or pop on the cycle after it occurs.
- rdata = mem[rd_ptr] combinationally.
  - After an accepted pop at edge N, rdata shows the next byte from edge N onward.
  - The consumer can therefore pop and sample on consecutive cycles: 16 pops in 16 cycles drain one block.
- Write latency: a byte written at edge N appears on rdata (if the FIFO was empty) and in count after edge N.
- Boundary conditions:
  - Write while full without pop: dropped. Contents, pointers and count unchanged.
  - Write and pop while full: both accepted, count stays DEPTH.
  - Pop while empty: ignored.
  - Write and pop while empty: write accepted, pop ignored, count -> 1.
- clear:
  - Priority over write and pop.
  - Pointers and count -> 0. Storage is not zeroed.
  - rdata is don't-care while empty.
- Reset mid-operation: any partially drained block is discarded. The downstream assembler must also be reset.

Optional Feature:
- Macro: USB_RX_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow and underflow (1 bit each), reset to 0.
  - overflow sets sticky on a dropped write. underflow sets sticky on an ignored pop.
  - Both cleared only by clear or n_rst.
  - Same-cycle clear wins over set.
- Undefined: these ports and registers do not exist; drop and ignore behaviour is unchanged.

Decomposition:
- Shared package usb_aes_pkg holds:
  - AES_BLOCK_BYTES=16.
  - USB_BYTE_W=8.
  - byte_t typedef (logic [7:0]).
  - aes_block_t typedef (logic [127:0]).
- Defaults for WIDTH and BLOCK_BYTES come from the package.
- One sub-module, fifo_regfile: DEPTH x WIDTH register array.
  - Async-reset to zero.
  - One synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- The top level holds pointers, count, flags and acceptance logic.

Test Plan:
- Reset then idle:
  - Expect empty=1, full=0, block_ready=0, count=0, rdata=8'h00.
- Write 8'h00..8'h0F on 16 consecutive cycles:
  - block_ready rises the cycle after the 16th write, with count=16.
  - Then pop for 16 consecutive cycles: rdata sequence 00..0F, and empty=1 after the last pop.
- Fill 32 bytes (8'hA0..8'hBF):
  - full=1 after the 32nd.
  - Write 8'hFF with no pop: dropped. count stays 32, and popping all yields A0..BF.
  - With the feature enabled, overflow=1.
- Write and pop together for 64 cycles from count=5:
  - count holds 5, and both pointers wrap twice.
  - Output order is preserved across the wrap, with no gaps or duplicates.
- Pop on empty, then write 8'h5A and pop in the same cycle on empty:
  - count -> 1, and rdata=8'h5A next cycle.
  - With the feature enabled, underflow=1 after the first pop.
- Load 20 bytes, assert clear together with write:
  - count=0 and empty=1 next cycle, and the concurrent write is lost.
  - Also assert n_rst low asynchronously mid-drain: all outputs return to reset values immediately.
